// File: rtl/display_word_assembler.sv
// Assembles two UART bytes (high then low) into a 16-bit display word,
// flagging bad bytes and inter-byte timeouts with a sticky flag and a counter.
module display_word_assembler #(
    parameter int          TIMEOUT_CYCLES = 50000,
    parameter logic [15:0] RESET_WORD     = 16'h0000,
    parameter logic [15:0] ERROR_WORD     = 16'hEEEE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_perror,
    input  logic        rx_ferror,
    output logic [15:0] data,
    output logic        data_update,
    output logic        error,
    output logic [7:0]  err_count
);

    typedef enum logic {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  hi_reg;
    logic [15:0] tmo_cnt;

    logic good_byte;
    logic bad_byte;
    logic tmo_hit;
    logic hi_take;
    logic word_done;
    logic err_evt;

    // Error bits only mean anything alongside the strobe.
    assign good_byte = rx_valid & ~rx_perror & ~rx_ferror;
    assign bad_byte  = rx_valid & (rx_perror | rx_ferror);

    // A strobe on the last counted cycle takes priority over the timeout.
    assign tmo_hit   = (state == WAIT_LO) && !rx_valid && (tmo_cnt == TMO_LAST);
    assign hi_take   = (state == WAIT_HI) && good_byte;
    assign word_done = (state == WAIT_LO) && good_byte;
    assign err_evt   = bad_byte | tmo_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= WAIT_HI;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_HI: if (good_byte)           state_nxt = WAIT_LO;
            WAIT_LO: if (rx_valid || tmo_hit) state_nxt = WAIT_HI;
            default:                          state_nxt = WAIT_HI;
        endcase
    end

    // Counter sits at zero outside WAIT_LO, so entering WAIT_LO starts from 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                        tmo_cnt <= '0;
        else if (state == WAIT_LO && !rx_valid && !tmo_hit) tmo_cnt <= tmo_cnt + 16'd1;
        else                                              tmo_cnt <= '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        hi_reg <= 8'h00;
        else if (hi_take) hi_reg <= rx_data;
        else if (err_evt) hi_reg <= 8'h00;
    end

    // data only moves on a completed word or a bad byte; a timeout leaves it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data        <= RESET_WORD;
            data_update <= 1'b0;
        end else begin
            data_update <= bad_byte | word_done;
            if (bad_byte)       data <= ERROR_WORD;
            else if (word_done) data <= {hi_reg, rx_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error     <= 1'b0;
            err_count <= 8'h00;
        end else if (err_evt) begin
            error <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_display_word_assembler.sv
// Directed bench for display_word_assembler with a short timeout (8 cycles).
module tb_display_word_assembler;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_perror;
    logic        rx_ferror;
    logic [15:0] data;
    logic        data_update;
    logic        error;
    logic [7:0]  err_count;

    int checks;
    int passes;

    display_word_assembler #(
        .TIMEOUT_CYCLES(8),
        .RESET_WORD    (16'h0000),
        .ERROR_WORD    (16'hEEEE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_perror  (rx_perror),
        .rx_ferror  (rx_ferror),
        .data       (data),
        .data_update(data_update),
        .error      (error),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic send_byte(input logic [7:0] b, input logic pe, input logic fe);
        @(negedge clk);
        rx_data   = b;
        rx_valid  = 1'b1;
        rx_perror = pe;
        rx_ferror = fe;
        @(negedge clk);
        rx_valid  = 1'b0;
        rx_perror = 1'b0;
        rx_ferror = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle(2);
        checks++; if (data !== 16'h0000) $display("FAIL reset_data: got %h expected %h", data, 16'h0000); else passes++;
        checks++; if (data_update !== 1'b0) $display("FAIL reset_update: got %b expected 0", data_update); else passes++;
        checks++; if (error !== 1'b0) $display("FAIL reset_error: got %b expected 0", error); else passes++;
        checks++; if (err_count !== 8'h00) $display("FAIL reset_errcnt: got %h expected 00", err_count); else passes++;
        reset = 1'b0;
    endtask

    task automatic test_good_word;
        send_byte(8'h12, 1'b0, 1'b0);
        checks++; if (data_update !== 1'b0) $display("FAIL hi_no_update: got %b expected 0", data_update); else passes++;
        idle(3);
        checks++; if (data !== 16'h0000) $display("FAIL hi_data_held: got %h expected %h", data, 16'h0000); else passes++;
        send_byte(8'h34, 1'b0, 1'b0);
        checks++; if (data !== 16'h1234) $display("FAIL word_1234: got %h expected %h", data, 16'h1234); else passes++;
        checks++; if (data_update !== 1'b1) $display("FAIL word_update: got %b expected 1", data_update); else passes++;
        checks++; if (error !== 1'b0) $display("FAIL word_error: got %b expected 0", error); else passes++;
        idle(1);
        checks++; if (data_update !== 1'b0) $display("FAIL update_one_cycle: got %b expected 0", data_update); else passes++;
        checks++; if (data !== 16'h1234) $display("FAIL word_held: got %h expected %h", data, 16'h1234); else passes++;
    endtask

    task automatic test_parity_error;
        send_byte(8'hAB, 1'b0, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        checks++; if (data !== 16'hEEEE) $display("FAIL perr_data: got %h expected %h", data, 16'hEEEE); else passes++;
        checks++; if (data_update !== 1'b1) $display("FAIL perr_update: got %b expected 1", data_update); else passes++;
        checks++; if (error !== 1'b1) $display("FAIL perr_error: got %b expected 1", error); else passes++;
        checks++; if (err_count !== 8'h01) $display("FAIL perr_errcnt: got %h expected 01", err_count); else passes++;
        send_byte(8'h56, 1'b0, 1'b0);
        send_byte(8'h78, 1'b0, 1'b0);
        checks++; if (data !== 16'h5678) $display("FAIL after_perr_word: got %h expected %h", data, 16'h5678); else passes++;
    endtask

    task automatic test_timeout;
        send_byte(8'h9A, 1'b0, 1'b0);
        idle(7);
        checks++; if (err_count !== 8'h01) $display("FAIL tmo_not_yet: got %h expected 01", err_count); else passes++;
        idle(1);
        checks++; if (err_count !== 8'h02) $display("FAIL tmo_errcnt: got %h expected 02", err_count); else passes++;
        checks++; if (data !== 16'h5678) $display("FAIL tmo_data_held: got %h expected %h", data, 16'h5678); else passes++;
        checks++; if (data_update !== 1'b0) $display("FAIL tmo_no_update: got %b expected 0", data_update); else passes++;
        send_byte(8'hC0, 1'b0, 1'b0);
        send_byte(8'hDE, 1'b0, 1'b0);
        checks++; if (data !== 16'hC0DE) $display("FAIL after_tmo_word: got %h expected %h", data, 16'hC0DE); else passes++;
    endtask

    task automatic test_lo_on_timeout;
        send_byte(8'h11, 1'b0, 1'b0);
        idle(6);
        send_byte(8'h22, 1'b0, 1'b0);
        checks++; if (data !== 16'h1122) $display("FAIL edge_word: got %h expected %h", data, 16'h1122); else passes++;
        checks++; if (data_update !== 1'b1) $display("FAIL edge_update: got %b expected 1", data_update); else passes++;
        idle(12);
        checks++; if (err_count !== 8'h02) $display("FAIL edge_no_tmo: got %h expected 02", err_count); else passes++;
    endtask

    task automatic test_both_errors_and_ignore;
        send_byte(8'h5A, 1'b1, 1'b1);
        checks++; if (err_count !== 8'h03) $display("FAIL both_err_single_inc: got %h expected 03", err_count); else passes++;
        checks++; if (data !== 16'hEEEE) $display("FAIL both_err_data: got %h expected %h", data, 16'hEEEE); else passes++;
        // Junk on the data/error lines without the strobe must be ignored.
        rx_data   = 8'hFF;
        rx_perror = 1'b1;
        rx_ferror = 1'b1;
        idle(4);
        rx_perror = 1'b0;
        rx_ferror = 1'b0;
        checks++; if (err_count !== 8'h03) $display("FAIL ignore_errcnt: got %h expected 03", err_count); else passes++;
        checks++; if (data_update !== 1'b0) $display("FAIL ignore_update: got %b expected 0", data_update); else passes++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes [4];
        bytes[0] = 8'hA1; bytes[1] = 8'hB2; bytes[2] = 8'hC3; bytes[3] = 8'hD4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rx_data  = bytes[i];
            rx_valid = 1'b1;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        checks++; if (data !== 16'hC3D4) $display("FAIL b2b_second_word: got %h expected %h", data, 16'hC3D4); else passes++;
        checks++; if (data_update !== 1'b1) $display("FAIL b2b_update: got %b expected 1", data_update); else passes++;
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h0F, 1'b0, 1'b0);
        checks++; if (data !== 16'h000F) $display("FAIL b2b_followup: got %h expected %h", data, 16'h000F); else passes++;
    endtask

    task automatic test_saturation;
        @(negedge clk);
        rx_data   = 8'h00;
        rx_valid  = 1'b1;
        rx_ferror = 1'b1;
        idle(252);
        checks++; if (err_count !== 8'hFF) $display("FAIL sat_reach: got %h expected FF", err_count); else passes++;
        idle(48);
        rx_valid  = 1'b0;
        rx_ferror = 1'b0;
        checks++; if (err_count !== 8'hFF) $display("FAIL sat_no_wrap: got %h expected FF", err_count); else passes++;
        checks++; if (data !== 16'hEEEE) $display("FAIL sat_data: got %h expected %h", data, 16'hEEEE); else passes++;
        checks++; if (error !== 1'b1) $display("FAIL sat_error: got %b expected 1", error); else passes++;
    endtask

    task automatic test_reset_mid_word;
        send_byte(8'h77, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        checks++; if (data !== 16'h0000) $display("FAIL async_reset_data: got %h expected %h", data, 16'h0000); else passes++;
        checks++; if (err_count !== 8'h00) $display("FAIL async_reset_errcnt: got %h expected 00", err_count); else passes++;
        checks++; if (error !== 1'b0) $display("FAIL async_reset_error: got %b expected 0", error); else passes++;
        idle(1);
        reset = 1'b0;
        send_byte(8'h43, 1'b0, 1'b0);
        checks++; if (data_update !== 1'b0) $display("FAIL post_reset_hi: got %b expected 0", data_update); else passes++;
        send_byte(8'h21, 1'b0, 1'b0);
        checks++; if (data !== 16'h4321) $display("FAIL post_reset_word: got %h expected %h", data, 16'h4321); else passes++;
    endtask

    initial begin
        checks    = 0;
        passes    = 0;
        reset     = 1'b1;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        rx_perror = 1'b0;
        rx_ferror = 1'b0;
        test_reset;
        test_good_word;
        test_parity_error;
        test_timeout;
        test_lo_on_timeout;
        test_both_errors_and_ignore;
        test_back_to_back;
        test_saturation;
        test_reset_mid_word;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/display_word_assembler.md
DISPLAY_WORD_ASSEMBLER -- requirements
Module: display_word_assembler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, inter-byte timeout in clk cycles (legal range 2..65535).
REQ-002 Parameter RESET_WORD, default 16'h0000, value of data after reset.
REQ-003 Parameter ERROR_WORD, default 16'hEEEE, value shown on data after a bad byte.
REQ-004 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-high reset.
REQ-006 Port: rx_data  in  8  received byte from the UART receiver; qualified by rx_valid.
REQ-007 Port: rx_valid  in  1  one-cycle strobe, byte present on rx_data.
REQ-008 Port: rx_perror  in  1  parity error for the strobed byte; sampled only when rx_valid=1.
REQ-009 Port: rx_ferror  in  1  framing error for the strobed byte; sampled only when rx_valid=1.
REQ-010 Port: data  out  16  display word for the four-digit LED driver, nibble [15:12] on the leftmost digit.
REQ-011 Port: data_update  out  1  one-cycle pulse, data changed on the preceding edge.
REQ-012 Port: error  out  1  sticky flag, at least one bad byte or timeout since reset.
REQ-013 Port: err_count  out  8  saturating count of bad bytes plus timeouts.

Function
REQ-014 Byte is good when rx_valid=1 and rx_perror=0 and rx_ferror=0, and bad when rx_valid=1 and either error bit=1.
REQ-015 FSM states are exactly WAIT_HI and WAIT_LO.
REQ-016 In WAIT_HI, a good byte is captured into hi_reg and the FSM goes to WAIT_LO.
REQ-017 On entry to WAIT_LO, the timeout counter is cleared to 0.
REQ-018 In WAIT_LO, on an edge with a good byte, data <= {hi_reg, rx_data}.
REQ-019 A WAIT_LO good byte also asserts data_update for the next cycle only, and the FSM returns to WAIT_HI.
REQ-020 In either state, on an edge with a bad byte, data <= ERROR_WORD and hi_reg is discarded.
REQ-021 A bad byte also asserts data_update for one cycle, sets error, increments err_count, and the FSM goes to WAIT_HI.
REQ-022 In WAIT_LO, the timeout counter increments on every cycle without rx_valid.
REQ-023 When the timeout counter equals TIMEOUT_CYCLES-1 and rx_valid=0: FSM goes to WAIT_HI, hi_reg is discarded, error sets, err_count increments, and data is unchanged with no data_update.
REQ-024 A byte strobe wins over a timeout on the same cycle; the byte is processed per REQ-018..021.
REQ-025 A strobe with both error bits set counts as one bad byte, with a single increment.
REQ-026 err_count saturates at 8'hFF and never wraps to 0.
REQ-027 data holds its value between updates, so the downstream multiplexer always sees a stable word.
REQ-028 Latency: data is valid on the edge that samples the completing rx_valid; data_update is high during the following cycle.
REQ-029 Back-to-back strobes on consecutive cycles are each processed with no byte lost.
REQ-030 rx_data, rx_perror and rx_ferror are ignored whenever rx_valid=0.

Reset
REQ-031 While reset=1, asynchronously: state=WAIT_HI, hi_reg=8'h00, timeout counter=0, data=RESET_WORD, data_update=0, error=0, err_count=8'h00.
REQ-032 A reset asserted in WAIT_LO discards the partial word; after release, the next good byte is treated as the high byte.
REQ-033 After reset release, the first rising edge behaves as a normal WAIT_HI cycle.

Verification
REQ-034 Reset, then good 8'h12 followed 3 cycles later by good 8'h34 -> data=16'h1234, data_update high exactly one cycle, error=0.
REQ-035 Good 8'hAB, then strobe with rx_perror=1 -> data=ERROR_WORD (16'hEEEE), error=1, err_count=1; next good pair 8'h56, 8'h78 -> data=16'h5678.
REQ-036 Good 8'h9A, then no strobe for TIMEOUT_CYCLES cycles (test TIMEOUT_CYCLES=8) -> WAIT_HI, data unchanged, err_count +1; next pair 8'hC0, 8'hDE -> 16'hC0DE.
REQ-037 With TIMEOUT_CYCLES=8, good hi byte, then good lo byte exactly on the timeout cycle -> word committed, no timeout counted.
REQ-038 300 consecutive strobes with rx_ferror=1 -> err_count stays at 8'hFF, data=ERROR_WORD.
REQ-039 Good hi byte, reset pulse, then good 8'h43, 8'h21 -> data=16'h4321, not a word using the pre-reset byte.
